vgachargen_apb_bridge: RTL and testbench
========================================

# vgachargen_apb_bridge

APB3 slave that gives the CPU word-level access to the character generator's three writable memories: the character map, the colour map and the RAM glyph table. It sits directly upstream of `vgachargen` and drives the A-ports of its dual-port BRAMs, which all have 1-cycle registered read latency. 32-bit writes into the 128-bit glyph rows are done by read-modify-write, so software never sees row width.

## Interface
Parameters:
- `CH_MAP_DEPTH`, 2400: valid entries in ch_map and col_map (80x30 cells).
- `CH_T_DEPTH`, 128: glyphs in ch_t_rw.

Ports (widths from `vgachargen_pkg`):
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset; synchronous and active-high.
- `psel_i`, `penable_i`, `pwrite_i`  in  1  APB3 control.
- `paddr_i`  in  16  byte address; bits [1:0] ignored.
- `pwdata_i`  in  32  write data.
- `prdata_o`  out  32  read data, zero-extended.
- `pready_o`, `pslverr_o`  out  1  APB3 response.
- `ch_map_addr_o`  out  CH_MAP_ADDR_WIDTH (12)
- `ch_map_data_o`  out  CH_MAP_DATA_WIDTH (8)
- `ch_map_wen_o`  out  1
- `ch_map_data_i`  in  8  BRAM read data, valid 1 cycle after address.
- `col_map_addr_o` 12, `col_map_data_o` 8, `col_map_wen_o` 1, `col_map_data_i` 8: same meaning for col_map.
- `ch_t_rw_addr_o` CH_T_ADDR_WIDTH (7), `ch_t_rw_data_o` 128, `ch_t_rw_wen_o` 1, `ch_t_rw_data_i` 128: same meaning for ch_t_rw.

## Operation
Address decode uses word index `idx = paddr_i[13:2]` and region `paddr_i[15:14]`:
- Region 0, ch_map: entry = idx. Write uses `pwdata[7:0]`; bit 7 selects the RAM glyph table.
- Region 1, col_map: entry = idx. Data is `pwdata[7:0]`, fg in [7:4], bg in [3:0].
- Region 2, ch_t_rw: glyph = idx[8:2], word w = idx[1:0]. Word w is row bits [32w+31:32w].
- Region 3: reserved.

Error conditions:
- Region 3, region 0/1 with idx ≥ CH_MAP_DEPTH, or region 2 with idx[11:9] ≠ 0.
- An error produces `pslverr_o`=1 with `pready_o`, makes no memory access, and returns `prdata_o`=0.

FSM states are IDLE, RD_ADDR, RD_CAPT, WRITE, RESP.
- IDLE: on `psel_i & ~penable_i` (setup phase), latch the decode and pwdata.
  - Error → RESP.
  - Write to region 0/1 → WRITE.
  - Read, or write to region 2 → RD_ADDR.
  - Drive the selected `*_addr_o` from the same edge.
- RD_ADDR: address held for the BRAM; go to RD_CAPT.
- RD_CAPT: capture `*_data_i`.
  - On a read, load `prdata_o` (the ch_t word is selected by w) and go to RESP.
  - On a ch_t write, form the merged row (word w replaced by pwdata, other 96 bits kept) and go to WRITE.
- WRITE: the selected `*_wen_o`=1 for exactly this cycle with `*_data_o` valid; go to RESP.
- RESP: `pready_o`=1 and `pslverr_o` valid. On `psel_i & penable_i`, go to IDLE.

Outputs and sequencing rules:
- Unselected memories keep `wen`=0. Addr/data outputs hold their last value.
- The sequence runs to completion even if psel drops mid-transfer. The response waits in RESP.
- Only one transfer is ever outstanding. A setup phase seen outside IDLE is ignored.

## Timing
- Reset (synchronous, `rst_i`=1 at an edge) puts the FSM in IDLE. All outputs become 0: pready, pslverr, prdata, every addr/data/wen.
- Reset mid-transfer aborts it: wen is deasserted the next cycle, and a pending RMW write is lost.
- Latency counts from the setup cycle T0; the cycle with pready=1 is:
  - ch_map/col_map write: T2 (1 wait state).
  - Any read: T3.
  - ch_t_rw write: T4 (wen in T3).
  - Error: T1.
- `prdata_o` is stable from the RESP cycle until the next read completes.
- The bridge does not arbitrate with the display port. The B-port read of the same cell in the write cycle returns old data (BRAM read-first).

## Test plan
- Write 0x41 to byte addr 0x0000, then read it back → `ch_map_wen_o` pulses at T1 with addr 0 and data 0x41; read returns `prdata_o`=0x00000041 with pready at T3.
- Write 0xA5 to byte addr 0x4000+4*2399 → `col_map_addr_o`=2399, wen in T1. Access to 0x4000+4*2400 → pslverr=1 at T1, no wen.
- Preload glyph 5 row = 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 and write 0xDEADBEEF to 0x8000+4*(5*4+2) → `ch_t_rw_wen_o` at T3 with data 0x0123_4567_DEAD_BEEF_0011_2233_4455_6677; pready at T4.
- Read region 3 (0xC000) → pslverr=1, prdata=0, pready at T1; next valid transfer unaffected.
- Assert `rst_i` during RD_CAPT of a ch_t write → no wen, all outputs 0 next cycle, FSM IDLE; the following ch_map write completes normally.
- Back-to-back transfers with penable held through a multi-cycle RESP → exactly one memory access per transfer.

Source files
------------

// File: rtl/vgachargen_apb_bridge.sv
// APB3 slave giving word-level access to the character map, colour map and
// RAM glyph table; 32-bit glyph writes are merged into 128-bit rows.
module vgachargen_apb_bridge #(
    parameter int CH_MAP_DEPTH = 2400,
    parameter int CH_T_DEPTH = 128,
    localparam int CH_MAP_ADDR_WIDTH = 12,
    localparam int CH_MAP_DATA_WIDTH = 8,
    localparam int CH_T_ADDR_WIDTH = 7,
    localparam int CH_T_DATA_WIDTH = 128
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         psel_i,
    input  logic                         penable_i,
    input  logic                         pwrite_i,
    input  logic [15:0]                  paddr_i,
    input  logic [31:0]                  pwdata_i,
    output logic [31:0]                  prdata_o,
    output logic                         pready_o,
    output logic                         pslverr_o,
    output logic [CH_MAP_ADDR_WIDTH-1:0] ch_map_addr_o,
    output logic [CH_MAP_DATA_WIDTH-1:0] ch_map_data_o,
    output logic                         ch_map_wen_o,
    input  logic [CH_MAP_DATA_WIDTH-1:0] ch_map_data_i,
    output logic [CH_MAP_ADDR_WIDTH-1:0] col_map_addr_o,
    output logic [CH_MAP_DATA_WIDTH-1:0] col_map_data_o,
    output logic                         col_map_wen_o,
    input  logic [CH_MAP_DATA_WIDTH-1:0] col_map_data_i,
    output logic [CH_T_ADDR_WIDTH-1:0]   ch_t_rw_addr_o,
    output logic [CH_T_DATA_WIDTH-1:0]   ch_t_rw_data_o,
    output logic                         ch_t_rw_wen_o,
    input  logic [CH_T_DATA_WIDTH-1:0]   ch_t_rw_data_i
);

    localparam logic [11:0] MAP_LIM = 12'(CH_MAP_DEPTH);
    localparam logic [9:0]  T_LIM   = 10'(CH_T_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_CAPT,
        WRITE,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic [1:0]  region;
    logic [11:0] idx;
    logic        setup;
    logic        access;
    logic        dec_err;
    logic        unused_lsb;

    logic [1:0]  region_q;
    logic [1:0]  word_q;
    logic        write_q;
    logic        err_q;
    logic [31:0] wdata_q;
    logic [CH_T_DATA_WIDTH-1:0] merged_row;

    assign region     = paddr_i[15:14];
    assign idx        = paddr_i[13:2];
    assign setup      = psel_i & ~penable_i;
    assign access     = psel_i & penable_i;
    assign unused_lsb = ^paddr_i[1:0];

    always_comb begin
        dec_err = 1'b1;
        unique case (region)
            2'd0, 2'd1: dec_err = (idx >= MAP_LIM);
            2'd2:       dec_err = (idx[11:2] >= T_LIM);
            default:    dec_err = 1'b1;
        endcase
    end

    always_comb begin
        merged_row = ch_t_rw_data_i;
        merged_row[{word_q, 5'b0} +: 32] = wdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    if (dec_err)
                        state_d = RESP;
                    else if (pwrite_i && region != 2'd2)
                        state_d = WRITE;
                    else
                        state_d = RD_ADDR;
                end
            end
            RD_ADDR: state_d = RD_CAPT;
            RD_CAPT: state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    if (access) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pready_o      = (state_q == RESP);
    assign pslverr_o     = pready_o & err_q;
    assign ch_map_wen_o  = (state_q == WRITE) && (region_q == 2'd0);
    assign col_map_wen_o = (state_q == WRITE) && (region_q == 2'd1);
    assign ch_t_rw_wen_o = (state_q == WRITE) && (region_q == 2'd2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            region_q       <= '0;
            word_q         <= '0;
            write_q        <= 1'b0;
            err_q          <= 1'b0;
            wdata_q        <= '0;
            prdata_o       <= '0;
            ch_map_addr_o  <= '0;
            ch_map_data_o  <= '0;
            col_map_addr_o <= '0;
            col_map_data_o <= '0;
            ch_t_rw_addr_o <= '0;
            ch_t_rw_data_o <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (setup) begin
                        region_q <= region;
                        word_q   <= idx[1:0];
                        write_q  <= pwrite_i;
                        err_q    <= dec_err;
                        wdata_q  <= pwdata_i;
                        if (dec_err) begin
                            prdata_o <= '0;
                        end else begin
                            unique case (region)
                                2'd0: begin
                                    ch_map_addr_o <= idx;
                                    if (pwrite_i) ch_map_data_o <= pwdata_i[7:0];
                                end
                                2'd1: begin
                                    col_map_addr_o <= idx;
                                    if (pwrite_i) col_map_data_o <= pwdata_i[7:0];
                                end
                                default: ch_t_rw_addr_o <= idx[8:2];
                            endcase
                        end
                    end
                end
                // Glyph writes only reach here as the read half of the RMW
                RD_CAPT: begin
                    if (write_q) begin
                        ch_t_rw_data_o <= merged_row;
                    end else begin
                        unique case (region_q)
                            2'd0:    prdata_o <= {24'h0, ch_map_data_i};
                            2'd1:    prdata_o <= {24'h0, col_map_data_i};
                            default: prdata_o <= ch_t_rw_data_i[{word_q, 5'b0} +: 32];
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vgachargen_apb_bridge.sv
// Bench for vgachargen_apb_bridge: BRAM models on the A-ports, directed
// vector table, reset-abort and held-response sequences, random traffic.
module tb_vgachargen_apb_bridge;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         psel_i, penable_i, pwrite_i;
    logic [15:0]  paddr_i;
    logic [31:0]  pwdata_i;
    logic [31:0]  prdata_o;
    logic         pready_o, pslverr_o;
    logic [11:0]  ch_map_addr_o, col_map_addr_o;
    logic [7:0]   ch_map_data_o, col_map_data_o;
    logic         ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o;
    logic [7:0]   ch_map_data_i, col_map_data_i;
    logic [6:0]   ch_t_rw_addr_o;
    logic [127:0] ch_t_rw_data_o, ch_t_rw_data_i;

    always #5 clk_i = ~clk_i;

    vgachargen_apb_bridge dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
        .pready_o(pready_o), .pslverr_o(pslverr_o),
        .ch_map_addr_o(ch_map_addr_o), .ch_map_data_o(ch_map_data_o),
        .ch_map_wen_o(ch_map_wen_o), .ch_map_data_i(ch_map_data_i),
        .col_map_addr_o(col_map_addr_o), .col_map_data_o(col_map_data_o),
        .col_map_wen_o(col_map_wen_o), .col_map_data_i(col_map_data_i),
        .ch_t_rw_addr_o(ch_t_rw_addr_o), .ch_t_rw_data_o(ch_t_rw_data_o),
        .ch_t_rw_wen_o(ch_t_rw_wen_o), .ch_t_rw_data_i(ch_t_rw_data_i)
    );

    // Read-first BRAMs with a backdoor port for preloading
    logic [7:0]   map_mem [0:4095];
    logic [7:0]   col_mem [0:4095];
    logic [127:0] cht_mem [0:127];
    logic         bd_we;
    logic [11:0]  bd_addr;
    logic [7:0]   bd_map, bd_col;
    logic [127:0] bd_cht;

    always @(posedge clk_i) begin
        if (bd_we) begin
            map_mem[bd_addr] <= bd_map;
            col_mem[bd_addr] <= bd_col;
            if (bd_addr < 12'd128) cht_mem[bd_addr[6:0]] <= bd_cht;
        end
        if (ch_map_wen_o)  map_mem[ch_map_addr_o]  <= ch_map_data_o;
        if (col_map_wen_o) col_mem[col_map_addr_o] <= col_map_data_o;
        if (ch_t_rw_wen_o) cht_mem[ch_t_rw_addr_o] <= ch_t_rw_data_o;
        ch_map_data_i  <= map_mem[ch_map_addr_o];
        col_map_data_i <= col_mem[col_map_addr_o];
        ch_t_rw_data_i <= cht_mem[ch_t_rw_addr_o];
    end

    int total_wen = 0;
    always @(negedge clk_i)
        if (ch_map_wen_o || col_map_wen_o || ch_t_rw_wen_o) total_wen++;

    // Reference model state
    logic [7:0]   ref_map [0:2399];
    logic [7:0]   ref_col [0:2399];
    logic [127:0] ref_cht [0:127];
    logic [31:0]  m_last = 32'h0;
    int           exp_total_wen = 0;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input logic wr, input logic [15:0] addr,
                         input logic [31:0] wd, output int e_lat,
                         output logic e_err, output logic [31:0] e_rd,
                         output int e_wmem, output logic [11:0] e_waddr,
                         output logic [127:0] e_wdat);
        int region, idx, g, w;
        logic [127:0] row;
        region  = int'(addr) / 16384;
        idx     = (int'(addr) % 16384) / 4;
        e_wmem  = 0;
        e_waddr = '0;
        e_wdat  = '0;
        e_err   = (region == 3) || (region < 2 && idx >= 2400) ||
                  (region == 2 && idx >= 4 * 128);
        if (e_err) begin
            e_lat  = 1;
            m_last = 32'h0;
        end else if (region < 2) begin
            if (wr) begin
                e_lat   = 2;
                e_wmem  = region + 1;
                e_waddr = 12'(idx);
                e_wdat  = {120'h0, wd[7:0]};
                if (region == 0) ref_map[idx] = wd[7:0];
                else             ref_col[idx] = wd[7:0];
                exp_total_wen++;
            end else begin
                e_lat  = 3;
                m_last = {24'h0, (region == 0) ? ref_map[idx] : ref_col[idx]};
            end
        end else begin
            g   = idx / 4;
            w   = idx % 4;
            row = ref_cht[g];
            if (wr) begin
                e_lat = 4;
                row[32*w +: 32] = wd;
                ref_cht[g] = row;
                e_wmem  = 3;
                e_waddr = 12'(g);
                e_wdat  = row;
                exp_total_wen++;
            end else begin
                e_lat  = 3;
                m_last = row[32*w +: 32];
            end
        end
        e_rd = m_last;
    endtask

    // Issues one APB transfer starting at a negedge; cycle k = Tk after setup
    task automatic xfer(input logic wr, input logic [15:0] addr,
                        input logic [31:0] wd, input int drop,
                        output int lat, output logic err,
                        output logic [31:0] rd, output int nwen,
                        output int wmem, output int wcyc,
                        output logic [11:0] waddr, output logic [127:0] wdat);
        bit done;
        lat = -1; err = 1'b0; rd = '0; nwen = 0; wmem = 0; wcyc = -1;
        waddr = '0; wdat = '0; done = 1'b0;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
        paddr_i = addr; pwdata_i = wd;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk_i);
            if (ch_map_wen_o) begin
                nwen++; wmem = 1; wcyc = k;
                waddr = ch_map_addr_o; wdat = {120'h0, ch_map_data_o};
            end
            if (col_map_wen_o) begin
                nwen++; wmem = 2; wcyc = k;
                waddr = col_map_addr_o; wdat = {120'h0, col_map_data_o};
            end
            if (ch_t_rw_wen_o) begin
                nwen++; wmem = 3; wcyc = k;
                waddr = {5'h0, ch_t_rw_addr_o}; wdat = ch_t_rw_data_o;
            end
            if (pready_o) begin
                lat = k; err = pslverr_o; rd = prdata_o;
                for (int j = 0; j < drop; j++) begin
                    @(negedge clk_i);
                    check("resp_hold", 128'(pready_o), 128'(1));
                end
                psel_i = 1'b1; penable_i = 1'b1;
                @(negedge clk_i);
                done = 1'b1;
            end else if (drop > 0) begin
                psel_i = 1'b0; penable_i = 1'b0;
            end else begin
                penable_i = 1'b1;
            end
        end
        psel_i = 1'b0; penable_i = 1'b0;
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout: no pready within 20 cycles, addr %h", addr);
        end
    endtask

    task automatic compare(input string tag, input int lat, input logic err,
                           input logic [31:0] rd, input int nwen,
                           input int wmem, input int wcyc,
                           input logic [11:0] waddr, input logic [127:0] wdat,
                           input int e_lat, input logic e_err,
                           input logic [31:0] e_rd, input int e_wmem,
                           input logic [11:0] e_waddr,
                           input logic [127:0] e_wdat);
        check({tag, " latency"}, 128'(lat), 128'(e_lat));
        check({tag, " pslverr"}, 128'(err), 128'(e_err));
        check({tag, " prdata"}, 128'(rd), 128'(e_rd));
        check({tag, " wen_count"}, 128'(nwen), 128'((e_wmem != 0) ? 1 : 0));
        if (e_wmem != 0) begin
            check({tag, " wen_mem"}, 128'(wmem), 128'(e_wmem));
            check({tag, " wen_cycle"}, 128'(wcyc), 128'(e_lat - 1));
            check({tag, " wen_addr"}, 128'(waddr), 128'(e_waddr));
            check({tag, " wen_data"}, wdat, e_wdat);
        end
    endtask

    task automatic run(input string tag, input logic wr,
                       input logic [15:0] addr, input logic [31:0] wd,
                       input int drop);
        int e_lat, e_wmem, lat, nwen, wmem, wcyc;
        logic e_err, err;
        logic [31:0] e_rd, rd;
        logic [11:0] e_waddr, waddr;
        logic [127:0] e_wdat, wdat;
        model(wr, addr, wd, e_lat, e_err, e_rd, e_wmem, e_waddr, e_wdat);
        xfer(wr, addr, wd, drop, lat, err, rd, nwen, wmem, wcyc, waddr, wdat);
        compare(tag, lat, err, rd, nwen, wmem, wcyc, waddr, wdat,
                e_lat, e_err, e_rd, e_wmem, e_waddr, e_wdat);
    endtask

    typedef struct {
        logic         wr;
        logic [15:0]  addr;
        logic [31:0]  wd;
        int           lat;
        logic         err;
        logic [31:0]  rd;
        int           wmem;
        logic [11:0]  waddr;
        logic [127:0] wdat;
    } vec_t;

    localparam logic [127:0] G5   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] G5W  = 128'h0123_4567_DEAD_BEEF_0011_2233_4455_6677;
    localparam logic [127:0] G127 = 128'hCAFE_F00D_0BAD_C0DE_1234_5678_9ABC_DEF0;

    vec_t tab [16];

    initial begin
        int lat, nwen, wmem, wcyc, d_lat, d_wmem;
        logic err, d_err;
        logic [31:0] rd, d_rd;
        logic [11:0] waddr, d_waddr;
        logic [127:0] wdat, d_wdat;

        tab[0]  = '{1'b1, 16'h0000, 32'h0000_0041, 2, 1'b0, 32'h0,  1, 12'd0,    128'h41};
        tab[1]  = '{1'b0, 16'h0000, 32'h0,         3, 1'b0, 32'h41, 0, 12'd0,    128'h0};
        tab[2]  = '{1'b1, 16'h0004, 32'hFFFF_FF83, 2, 1'b0, 32'h41, 1, 12'd1,    128'h83};
        tab[3]  = '{1'b0, 16'h0004, 32'h0,         3, 1'b0, 32'h83, 0, 12'd0,    128'h0};
        tab[4]  = '{1'b1, 16'h657C, 32'h0000_00A5, 2, 1'b0, 32'h83, 2, 12'd2399, 128'hA5};
        tab[5]  = '{1'b1, 16'h6580, 32'h0000_0077, 1, 1'b1, 32'h0,  0, 12'd0,    128'h0};
        tab[6]  = '{1'b0, 16'h657C, 32'h0,         3, 1'b0, 32'hA5, 0, 12'd0,    128'h0};
        tab[7]  = '{1'b1, 16'h8058, 32'hDEAD_BEEF, 4, 1'b0, 32'hA5, 3, 12'd5,    G5W};
        tab[8]  = '{1'b0, 16'h8058, 32'h0,         3, 1'b0, 32'hDEAD_BEEF, 0, 12'd0, 128'h0};
        tab[9]  = '{1'b0, 16'h8054, 32'h0,         3, 1'b0, 32'h0011_2233, 0, 12'd0, 128'h0};
        tab[10] = '{1'b0, 16'hC000, 32'h0,         1, 1'b1, 32'h0,  0, 12'd0,    128'h0};
        tab[11] = '{1'b0, 16'h0000, 32'h0,         3, 1'b0, 32'h41, 0, 12'd0,    128'h0};
        tab[12] = '{1'b0, 16'h8800, 32'h0,         1, 1'b1, 32'h0,  0, 12'd0,    128'h0};
        tab[13] = '{1'b1, 16'h2580, 32'h1234_5678, 1, 1'b1, 32'h0,  0, 12'd0,    128'h0};
        tab[14] = '{1'b0, 16'h87FC, 32'h0,         3, 1'b0, 32'hCAFE_F00D, 0, 12'd0, 128'h0};
        tab[15] = '{1'b0, 16'h0003, 32'h0,         3, 1'b0, 32'h41, 0, 12'd0,    128'h0};

        rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        paddr_i = '0; pwdata_i = '0;
        bd_we = 1'b0; bd_addr = '0; bd_map = '0; bd_col = '0; bd_cht = '0;

        for (int a = 0; a < 2400; a++) begin
            @(negedge clk_i);
            bd_we   = 1'b1;
            bd_addr = 12'(a);
            bd_map  = 8'($urandom);
            bd_col  = 8'($urandom);
            bd_cht  = {$urandom, $urandom, $urandom, $urandom};
            if (a == 5)   bd_cht = G5;
            if (a == 127) bd_cht = G127;
            ref_map[a] = bd_map;
            ref_col[a] = bd_col;
            if (a < 128) ref_cht[a] = bd_cht;
        end
        @(negedge clk_i);
        bd_we = 1'b0;
        @(negedge clk_i);

        check("reset pready", 128'(pready_o), 128'(0));
        check("reset pslverr", 128'(pslverr_o), 128'(0));
        check("reset prdata", 128'(prdata_o), 128'(0));
        check("reset addrs", 128'({ch_map_addr_o, col_map_addr_o, ch_t_rw_addr_o}), 128'(0));
        check("reset map data", 128'({ch_map_data_o, col_map_data_o}), 128'(0));
        check("reset cht data", ch_t_rw_data_o, 128'(0));
        check("reset wens", 128'({ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o}), 128'(0));
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < 16; i++) begin
            model(tab[i].wr, tab[i].addr, tab[i].wd,
                  d_lat, d_err, d_rd, d_wmem, d_waddr, d_wdat);
            xfer(tab[i].wr, tab[i].addr, tab[i].wd, 0,
                 lat, err, rd, nwen, wmem, wcyc, waddr, wdat);
            compare($sformatf("vec%0d", i), lat, err, rd, nwen, wmem, wcyc,
                    waddr, wdat, tab[i].lat, tab[i].err, tab[i].rd,
                    tab[i].wmem, tab[i].waddr, tab[i].wdat);
        end

        run("held_resp_wr", 1'b1, 16'h000C, 32'h0000_003C, 3);
        run("held_resp_rd", 1'b0, 16'h000C, 32'h0, 2);
        run("held_resp_cht", 1'b1, 16'h8100, 32'h5555_AAAA, 1);

        // Reset lands while the glyph write is capturing its row
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
        paddr_i = 16'h80A0; pwdata_i = 32'h1234_5678;
        @(negedge clk_i);
        penable_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("abort pready", 128'(pready_o), 128'(0));
        check("abort prdata", 128'(prdata_o), 128'(0));
        check("abort wens", 128'({ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o}), 128'(0));
        check("abort addrs", 128'({ch_map_addr_o, col_map_addr_o, ch_t_rw_addr_o}), 128'(0));
        check("abort cht data", ch_t_rw_data_o, 128'(0));
        rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
        m_last = 32'h0;
        @(negedge clk_i);
        run("post_abort_wr", 1'b1, 16'h0008, 32'h0000_005A, 0);
        run("post_abort_glyph", 1'b0, 16'h80A0, 32'h0, 0);
        run("post_abort_rd", 1'b0, 16'h0008, 32'h0, 0);

        for (int i = 0; i < 300; i++) begin
            int region, r, idx, lim, drop;
            logic wr;
            logic [15:0] a;
            region = int'($urandom_range(0, 3));
            r      = int'($urandom_range(0, 9));
            lim    = (region == 2) ? 512 : 2400;
            if (r < 4)       idx = int'($urandom_range(0, 15));
            else if (r < 7)  idx = int'($urandom_range(0, 32'(lim - 1)));
            else if (r == 7) idx = lim - 1 + int'($urandom_range(0, 1));
            else             idx = int'($urandom_range(0, 4095));
            a    = 16'((region << 14) | (idx << 2) | int'($urandom_range(0, 3)));
            wr   = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            run($sformatf("rnd%0d", i), wr, a, $urandom, drop);
        end

        repeat (2) @(negedge clk_i);
        check("total_wen", 128'(total_wen), 128'(exp_total_wen));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
